// File: rtl/pkt_reader.sv
// Descriptor-driven packet reader: walks a ring buffer from a start address
// and streams the words out with sop/eop framing and ready/valid handshake.
module pkt_reader #(
  parameter int pBITS   = 8,
  parameter int pDEPTH  = 3072,
  parameter int pADDR_W = 12,
  parameter int pLEN_W  = 13
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               idesc_valid,
  output logic               odesc_ready,
  input  logic [pADDR_W-1:0] idesc_addr,
  input  logic [pLEN_W-1:0]  idesc_len,
  output logic [pADDR_W-1:0] or_addr,
  input  logic [pBITS-1:0]   ir_data,
  output logic [pBITS-1:0]   odata,
  output logic               ovalid,
  output logic               osop,
  output logic               oeop,
  input  logic               iready,
  output logic               oerr,
  output logic [15:0]        opkt_cnt
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [31:0] DEPTH_U = 32'(pDEPTH);

  state_t             state, state_nxt;
  logic [pADDR_W-1:0] ptr;
  logic [pLEN_W-1:0]  rem;
  logic               first;
  logic               desc_take, desc_bad, load, take_eop;

  // Ring depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [pADDR_W-1:0] ptr_inc(input logic [pADDR_W-1:0] p);
    if (32'(p) == DEPTH_U - 32'd1) return '0;
    return p + pADDR_W'(1);
  endfunction

  assign odesc_ready = (state == IDLE) && !irst;
  assign or_addr     = ptr;

  always_comb begin
    desc_take = (state == IDLE) && idesc_valid;
    desc_bad  = (idesc_len == '0) || (32'(idesc_len) > DEPTH_U) ||
                (32'(idesc_addr) >= DEPTH_U);
    load      = (state == STREAM) && (!ovalid || iready);
    take_eop  = ovalid && iready && oeop;
    state_nxt = state;
    case (state)
      IDLE:    if (desc_take && !desc_bad) state_nxt = STREAM;
      STREAM:  if (load && rem == pLEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (take_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Single output register stage: refilled whenever empty or being drained.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ptr      <= '0;
      rem      <= '0;
      first    <= 1'b0;
      odata    <= '0;
      ovalid   <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      oerr     <= 1'b0;
      opkt_cnt <= '0;
    end else begin
      oerr <= 1'b0;
      if (desc_take) begin
        if (desc_bad) begin
          oerr <= 1'b1;
        end else begin
          ptr   <= idesc_addr;
          rem   <= idesc_len;
          first <= 1'b1;
        end
      end
      if (load) begin
        odata  <= ir_data;
        ovalid <= 1'b1;
        osop   <= first;
        oeop   <= (rem == pLEN_W'(1));
        ptr    <= ptr_inc(ptr);
        rem    <= rem - pLEN_W'(1);
        first  <= 1'b0;
      end else if (ovalid && iready) begin
        ovalid <= 1'b0;
        osop   <= 1'b0;
        oeop   <= 1'b0;
      end
      if (take_eop) opkt_cnt <= opkt_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pkt_reader.md
PKT_READER -- requirements
Module: pkt_reader

Interface
REQ-001 SHALL have parameter pBITS, 8, data width of buffer word and output stream.
REQ-002 SHALL have parameter pDEPTH, 3072, number of buffer words (ring size).
REQ-003 SHALL have parameter pADDR_W, 12, buffer address width.
REQ-004 SHALL have parameter pLEN_W, 13, descriptor length width (must hold pDEPTH).
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports iclk input 1, the single clock; irst input 1, the reset.
REQ-006 SHALL have idesc_valid input 1, a descriptor is offered.
REQ-007 SHALL have odesc_ready output 1, the block accepts a descriptor.
REQ-008 SHALL have idesc_addr input pADDR_W, first buffer word of the packet.
REQ-009 SHALL have idesc_len input pLEN_W, packet length in words.
REQ-010 SHALL have or_addr output pADDR_W, buffer read address (buffer read is combinational).
REQ-011 SHALL have ir_data input pBITS, buffer read data for or_addr, same cycle.
REQ-012 SHALL have odata output pBITS, stream data.
REQ-013 SHALL have ovalid output 1, odata valid.
REQ-014 SHALL have osop output 1, first word of packet, qualified by ovalid.
REQ-015 SHALL have oeop output 1, last word of packet, qualified by ovalid.
REQ-016 SHALL have iready input 1, downstream accepts the word.
REQ-017 SHALL have oerr output 1, one-cycle pulse on a rejected descriptor.
REQ-018 SHALL have opkt_cnt output 16, count of completed packets.

Function
REQ-019 SHALL implement FSM states IDLE, STREAM, DRAIN; odesc_ready = 1 only in IDLE.
REQ-020 SHALL accept a descriptor on a rising edge with idesc_valid & odesc_ready.
REQ-021 SHALL reject an accepted descriptor with idesc_len == 0, idesc_len > pDEPTH or idesc_addr >= pDEPTH: oerr = 1 for the next cycle, state stays IDLE, no output.
REQ-022 SHALL, on a valid accept, load read pointer = idesc_addr and remaining = idesc_len, and enter STREAM.
REQ-023 SHALL drive or_addr = read pointer at all times.
REQ-024 SHALL, in STREAM, load the output register (odata <= ir_data, ovalid <= 1) when it is empty or (ovalid & iready) holds, then advance the pointer and decrement remaining.
REQ-025 SHALL wrap the pointer from pDEPTH-1 to 0, by explicit compare and not by power-of-two truncation.
REQ-026 SHALL set osop with the first loaded word and oeop with the word loaded when remaining == 1.
REQ-027 SHALL enter DRAIN after loading the last word, and go to IDLE on the edge where that word is accepted (ovalid & iready & oeop).
REQ-028 SHALL hold odata, osop, oeop and ovalid stable while ovalid & !iready.
REQ-029 SHALL clear ovalid on acceptance when no new word is loaded.
REQ-030 SHALL make the first word valid in the cycle after STREAM entry (2 edges after accept), with 1 word/cycle throughput under continuous iready.
REQ-031 SHALL increment opkt_cnt by 1 mod 2^16 on each oeop acceptance.
REQ-032 SHALL ignore idesc_valid outside IDLE, with no queuing.
REQ-033 SHALL handle single-word packets with osop = oeop = 1 on the same word.

Reset
REQ-034 SHALL, with irst high at a rising edge, set state IDLE, and set ovalid, osop, oeop, oerr to 0.
REQ-035 SHALL, with irst high at a rising edge, set odata, pointer, remaining and opkt_cnt to 0.
REQ-036 SHALL, when reset arrives mid-packet, abort the packet with no oeop and no count.
REQ-037 SHALL hold odesc_ready = 0 during reset and = 1 in the first cycle after reset release.

Verification
REQ-038 SHALL be verified with: buffer[i]=i, desc addr=10 len=4, iready=1 -> odata 10,11,12,13 on consecutive cycles, osop on 10, oeop on 13, opkt_cnt=1.
REQ-039 SHALL be verified with: desc addr=3070 len=4 -> read addresses 3070, 3071, 0, 1 in order.
REQ-040 SHALL be verified with: len=3, iready low for 3 cycles on word 2 -> word 2 held stable, no loss or duplication, oeop on word 3.
REQ-041 SHALL be verified with: desc len=0, then len=3073, then addr=3072 -> oerr pulses 3 times, ovalid never high, opkt_cnt unchanged.
REQ-042 SHALL be verified with: len=1 -> single word with osop=oeop=1 and odesc_ready back high the cycle after acceptance.
REQ-043 SHALL be verified with: irst asserted after 2 of 5 words -> ovalid=0 next cycle, odesc_ready=1 after release, next packet streams correctly.
